// File: rtl/rx_mac_v2_if.sv
// Byte-stream bus for rx_mac_v2: PHY-side receive bytes in, payload stream out.
// The slave modport is the MAC's view; master is the PHY/consumer side.
interface rx_mac_v2_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;

  modport master (
    output rx_data, rx_valid, rx_last,
    input  m_data, m_valid, m_last, m_err
  );

  modport slave (
    input  rx_data, rx_valid, rx_last,
    output m_data, m_valid, m_last, m_err
  );
endinterface

// File: rtl/rx_mac_v2.sv
// Ethernet RX MAC: preamble/SFD strip, header extract + dest filter, FCS strip, length checks.
// Optional CRC-32 FCS checking is enabled by defining RX_MAC_FCS_CHECK_EN.
module rx_mac_v2 #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned PREAMBLE_MIN  = 1,
  parameter int unsigned ACCEPT_MCAST  = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  rx_mac_v2_if.slave       bus,
  input  logic [47:0]      station_mac,
  input  logic             promisc,
  output logic             hdr_valid,
  output logic [47:0]      hdr_dest_mac,
  output logic [47:0]      hdr_src_mac,
  output logic [15:0]      hdr_type,
  output logic [CNT_W-1:0] cnt_frames_ok,
  output logic [CNT_W-1:0] cnt_frames_drop
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned HDR_W = 112;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_DROP} state_e;

  state_e               state_q;
  logic [3:0]           pre_cnt_q;
  logic [3:0]           hdr_idx_q;
  logic [HDR_W-9:0]     hdr_q;
  logic [3:0][7:0]      dly_q;
  logic [2:0]           fill_q;
  logic [LEN_W-1:0]     len_q;
  logic [7:0]           m_data_q;
  logic                 m_valid_q, m_last_q, m_err_q, hdr_valid_q;
  logic [47:0]          hdr_dest_q, hdr_src_q;
  logic [15:0]          hdr_type_q;
  logic [CNT_W-1:0]     cnt_ok_q, cnt_drop_q;

  logic [HDR_W-1:0]     hdr_d;
  logic [LEN_W-1:0]     len_d;
  logic [47:0]          dest_c;
  logic                 accept_c, fcs_bad_c, frame_err_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Header shift register: after byte 13, hdr_d holds dest|src|type MSB-first.
  assign hdr_d    = {hdr_q, bus.rx_data};
  assign len_d    = (&len_q) ? len_q : len_q + LEN_W'(1);
  assign dest_c   = hdr_d[111:64];
  assign accept_c = promisc || (dest_c == station_mac) || (&dest_c) ||
                    ((ACCEPT_MCAST != 0) && dest_c[40]);

`ifdef RX_MAC_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_rev_c;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  // Reflected register over data+FCS leaves the bit-reversed magic residue.
  assign crc_d     = crc_byte(crc_q, bus.rx_data);
  assign crc_rev_c = {<<{crc_d}};
  assign fcs_bad_c = (crc_rev_c != 32'hC704DD7B);
`else
  assign fcs_bad_c = 1'b0;
`endif

  assign frame_err_c = (32'(len_d) < MIN_FRAME_LEN) || (32'(len_d) > MAX_FRAME_LEN) || fcs_bad_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      hdr_idx_q    <= '0;
      hdr_q        <= '0;
      dly_q        <= '0;
      fill_q       <= '0;
      len_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_err_q      <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_dest_q   <= '0;
      hdr_src_q    <= '0;
      hdr_type_q   <= '0;
      cnt_ok_q     <= '0;
      cnt_drop_q   <= '0;
`ifdef RX_MAC_FCS_CHECK_EN
      crc_q        <= '0;
`endif
    end else begin
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_err_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      if (bus.rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (bus.rx_data == 8'h55) begin
              state_q   <= S_PRE;
              pre_cnt_q <= 4'd1;
            end
          end
          S_PRE: begin
            if (bus.rx_data == 8'h55) begin
              if (pre_cnt_q != 4'hF) pre_cnt_q <= pre_cnt_q + 4'd1;
            end else if ((bus.rx_data == 8'hD5) && (32'(pre_cnt_q) >= PREAMBLE_MIN)) begin
              state_q   <= S_HDR;
              hdr_idx_q <= '0;
              len_q     <= '0;
`ifdef RX_MAC_FCS_CHECK_EN
              crc_q     <= 32'hFFFFFFFF;
`endif
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_HDR: begin
            hdr_q     <= hdr_d[HDR_W-9:0];
            len_q     <= len_d;
            hdr_idx_q <= hdr_idx_q + 4'd1;
`ifdef RX_MAC_FCS_CHECK_EN
            crc_q     <= crc_d;
`endif
            if (bus.rx_last) begin
              state_q    <= S_IDLE;
              cnt_drop_q <= sat_inc(cnt_drop_q);
            end else if (hdr_idx_q == 4'd13) begin
              if (accept_c) begin
                state_q     <= S_PAY;
                fill_q      <= '0;
                hdr_valid_q <= 1'b1;
                hdr_dest_q  <= dest_c;
                hdr_src_q   <= hdr_d[63:16];
                hdr_type_q  <= hdr_d[15:0];
              end else begin
                state_q    <= S_DROP;
                cnt_drop_q <= sat_inc(cnt_drop_q);
              end
            end
          end
          S_PAY: begin
            // Four-byte delay line keeps the trailing FCS from ever reaching the output.
            dly_q <= {dly_q[2:0], bus.rx_data};
            len_q <= len_d;
`ifdef RX_MAC_FCS_CHECK_EN
            crc_q <= crc_d;
`endif
            if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
            if (bus.rx_last) begin
              state_q <= S_IDLE;
              if (fill_q == 3'd4) begin
                m_valid_q <= 1'b1;
                m_last_q  <= 1'b1;
                m_err_q   <= frame_err_c;
                m_data_q  <= dly_q[3];
                if (frame_err_c) cnt_drop_q <= sat_inc(cnt_drop_q);
                else             cnt_ok_q   <= sat_inc(cnt_ok_q);
              end else begin
                cnt_drop_q <= sat_inc(cnt_drop_q);
              end
            end else if (32'(len_d) > MAX_FRAME_LEN) begin
              state_q    <= S_DROP;
              m_valid_q  <= 1'b1;
              m_last_q   <= 1'b1;
              m_err_q    <= 1'b1;
              m_data_q   <= '0;
              cnt_drop_q <= sat_inc(cnt_drop_q);
            end else if (fill_q == 3'd4) begin
              m_valid_q <= 1'b1;
              m_data_q  <= dly_q[3];
            end
          end
          S_DROP: begin
            if (bus.rx_last) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.m_data      = m_data_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_last      = m_last_q;
  assign bus.m_err       = m_err_q;
  assign hdr_valid       = hdr_valid_q;
  assign hdr_dest_mac    = hdr_dest_q;
  assign hdr_src_mac     = hdr_src_q;
  assign hdr_type        = hdr_type_q;
  assign cnt_frames_ok   = cnt_ok_q;
  assign cnt_frames_drop = cnt_drop_q;

endmodule

// File: tb/tb_rx_mac_v2.sv
// Self-checking bench for rx_mac_v2: frame-level reference model, per-cycle output compare.
// Corrupted-FCS scenario runs only when RX_MAC_FCS_CHECK_EN is defined.
module tb_rx_mac_v2;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
`ifdef RX_MAC_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif
  localparam logic [47:0] STA = 48'h02_00_00_00_00_AA;
  localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] station_mac;
  logic        promisc;
  logic        hdr_valid;
  logic [47:0] hdr_dest_mac, hdr_src_mac;
  logic [15:0] hdr_type;
  logic [31:0] cnt_frames_ok, cnt_frames_drop;

  rx_mac_v2_if bus();

  rx_mac_v2 dut (
    .clk(clk), .rst(rst), .bus(bus),
    .station_mac(station_mac), .promisc(promisc),
    .hdr_valid(hdr_valid), .hdr_dest_mac(hdr_dest_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_type(hdr_type), .cnt_frames_ok(cnt_frames_ok), .cnt_frames_drop(cnt_frames_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic last; logic err;} beat_t;
  typedef struct packed {logic [47:0] d; logic [47:0] s; logic [15:0] t;} hdr_t;

  beat_t       exp_q[$];
  hdr_t        exp_hdr_q[$];
  logic [7:0]  frame_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_ok = 0, exp_drop = 0;
  beat_t       mon_b;
  hdr_t        mon_h;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  // Frame bytes from dest MAC through FCS (FCS sent LSB first).
  task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int plen);
    logic [31:0] c;
    frame_q.delete();
    for (int i = 5; i >= 0; i--) frame_q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frame_q.push_back(s[i*8 +: 8]);
    frame_q.push_back(t[15:8]);
    frame_q.push_back(t[7:0]);
    for (int i = 0; i < plen; i++) frame_q.push_back(8'(i));
    c = 32'hFFFFFFFF;
    foreach (frame_q[i]) c = crc_upd(c, frame_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[i*8 +: 8]);
  endtask

  function automatic bit fcs_ok();
    logic [31:0] c;
    int n;
    n = frame_q.size();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) c = crc_upd(c, frame_q[i]);
    c = ~c;
    return c == {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
  endfunction

  // Frame-level expectation: what the receiver must emit for frame_q.
  task automatic predict(input logic [47:0] sta, input bit prom);
    int n;
    logic [47:0] d, s;
    bit acc, err;
    n = frame_q.size();
    if (n <= 14) begin exp_drop++; return; end
    d = '0; s = '0;
    for (int i = 0; i < 6; i++) d = {d[39:0], frame_q[i]};
    for (int i = 6; i < 12; i++) s = {s[39:0], frame_q[i]};
    acc = prom || (d == sta) || (d == 48'hFFFF_FFFF_FFFF) || d[40];
    if (!acc) begin exp_drop++; return; end
    exp_hdr_q.push_back({d, s, frame_q[12], frame_q[13]});
    if (n > MAX_LEN + 1) begin
      for (int i = 14; i < MAX_LEN - 4; i++) exp_q.push_back({frame_q[i], 1'b0, 1'b0});
      exp_q.push_back({8'h00, 1'b1, 1'b1});
      exp_drop++;
      return;
    end
    if (n - 18 <= 0) begin exp_drop++; return; end
    err = (n < MIN_LEN) || (n > MAX_LEN) || (FCS_EN && !fcs_ok());
    for (int i = 14; i <= n - 5; i++)
      exp_q.push_back({frame_q[i], i == n - 5, (i == n - 5) ? err : 1'b0});
    if (err) exp_drop++; else exp_ok++;
  endtask

  task automatic put(input logic [7:0] b, input bit l, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(3, 1)) : 0;
    if (g > 0) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
      repeat (g - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_last  = l;
  endtask

  task automatic send(input int npre, input bit gaps, input int stop_at);
    for (int i = 0; i < npre; i++) put(8'h55, 1'b0, gaps);
    put(8'hD5, 1'b0, gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (stop_at >= 0 && i > stop_at) break;
      put(frame_q[i], i == frame_q.size() - 1, gaps);
    end
  endtask

  task automatic finish_frame(input string tag);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_hdr_left"}, exp_hdr_q.size(), 0);
    check({tag, "_cnt_ok"}, cnt_frames_ok, exp_ok);
    check({tag, "_cnt_drop"}, cnt_frames_drop, exp_drop);
    exp_q.delete();
    exp_hdr_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_last"}, bus.m_last, 0);
    check({tag, "_m_err"}, bus.m_err, 0);
    check({tag, "_hdr_valid"}, hdr_valid, 0);
    check({tag, "_hdr_fields"}, {hdr_dest_mac, hdr_src_mac, hdr_type}, 0);
    check({tag, "_counters"}, {cnt_frames_ok, cnt_frames_drop}, 0);
  endtask

  // Every out-of-reset cycle: each valid beat and header pulse must match the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.m_valid === 1'b1) begin
        if (exp_q.size() == 0) fail("unexpected_beat", {bus.m_data, bus.m_last, bus.m_err}, 0);
        else begin
          mon_b = exp_q.pop_front();
          check("beat", {bus.m_data, bus.m_last, bus.m_err}, mon_b);
        end
      end else begin
        check("idle_last_err", {bus.m_last, bus.m_err}, 0);
      end
      if (hdr_valid === 1'b1) begin
        if (exp_hdr_q.size() == 0) fail("unexpected_hdr", {hdr_dest_mac, hdr_src_mac, hdr_type}, 0);
        else begin
          mon_h = exp_hdr_q.pop_front();
          check("hdr", {hdr_dest_mac, hdr_src_mac, hdr_type}, mon_h);
        end
      end
    end
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    station_mac  = STA;
    promisc      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 64-byte unicast frame
    build(STA, SRC, 16'h0800, 46);
    predict(STA, 1'b0);
    check("model_t1_beats", exp_q.size(), 46);
    check("model_t1_lastbeat", exp_q[45], {8'h2D, 1'b1, 1'b0});
    send(7, 1'b0, -1);
    finish_frame("t1");
    check("t1_cnt_ok_lit", cnt_frames_ok, 1);
    check("t1_hdr_lit", {hdr_dest_mac, hdr_src_mac, hdr_type}, {STA, SRC, 16'h0800});

    // Foreign unicast: rejected, then delivered under promisc
    build(48'h02_11_22_33_44_55, SRC, 16'h0800, 46);
    predict(STA, 1'b0);
    send(7, 1'b0, -1);
    finish_frame("reject");
    check("reject_drop_lit", cnt_frames_drop, 1);
    promisc = 1'b1;
    predict(STA, 1'b1);
    send(7, 1'b0, -1);
    finish_frame("promisc");
    promisc = 1'b0;

    // Multicast group bit, minimum one-byte preamble
    build(48'h03_00_5E_00_00_01, SRC, 16'h86DD, 50);
    predict(STA, 1'b0);
    send(1, 1'b0, -1);
    finish_frame("mcast");

    // Broadcast runt: 28-byte frame
    build(48'hFFFF_FFFF_FFFF, SRC, 16'h0806, 10);
    predict(STA, 1'b0);
    check("model_runt_beats", exp_q.size(), 10);
    check("model_runt_err", exp_q[9].err, 1);
    send(7, 1'b0, -1);
    finish_frame("runt");

    // Header-only frame: nothing delivered
    build(STA, SRC, 16'h0800, 0);
    predict(STA, 1'b0);
    send(7, 1'b0, -1);
    finish_frame("empty");

    // Oversize: 1600 bytes
    build(STA, SRC, 16'h0800, 1600 - 18);
    predict(STA, 1'b0);
    check("model_long_beats", exp_q.size(), 1501);
    send(7, 1'b0, -1);
    finish_frame("long");

    // Basic frame with random 1-3 cycle gaps
    build(STA, SRC, 16'h0800, 46);
    predict(STA, 1'b0);
    send(7, 1'b1, -1);
    finish_frame("gaps");

`ifdef RX_MAC_FCS_CHECK_EN
    build(STA, SRC, 16'h0800, 46);
    frame_q[20] = frame_q[20] ^ 8'h04;
    predict(STA, 1'b0);
    check("model_fcs_err", exp_q[45].err, 1);
    send(7, 1'b0, -1);
    finish_frame("fcs");
`endif

    // Reset mid-payload, then a clean frame
    build(STA, SRC, 16'h0800, 46);
    predict(STA, 1'b0);
    send(7, 1'b0, 30);
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    exp_q.delete();
    exp_hdr_q.delete();
    exp_ok   = 0;
    exp_drop = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    predict(STA, 1'b0);
    send(7, 1'b0, -1);
    finish_frame("after_rst");
    check("after_rst_ok_lit", cnt_frames_ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
